// File: rtl/cute_lock_pkg.sv
// Shared definitions for the time-varying key sequencer: default geometry
// of the lock schedule and the sequencer state encoding.
package cute_lock_pkg;

    // Default key word width (keyinput bits of the locked core).
    localparam int DEFAULT_KEY_W      = 3;
    // Default number of lock-counter phases.
    localparam int DEFAULT_NUM_STATES = 4;
    // Default phase the locked core's counter holds in its first enabled cycle.
    localparam int DEFAULT_INIT_PHASE = 0;
    // Phase index width for the default schedule length.
    localparam int PHASE_W            = $clog2(DEFAULT_NUM_STATES);

    // Sequencer states: empty, partially loaded, loaded and waiting, replaying.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        RUN   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/cute_lock_phase_counter.sv
// Modulo-NUM_STATES phase counter with clear, load-to-INIT_PHASE and enable.
// The same counter is used by the lock-insertion models, so the trusted side
// and the locked core wrap at exactly the same point. count_next exposes the
// value the counter will take on the coming edge so that a schedule lookup
// can be registered in the same cycle as the phase.
module cute_lock_phase_counter #(
    parameter int NUM_STATES = 4,
    parameter int INIT_PHASE = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          load,
    input  logic                          enable,
    output logic [$clog2(NUM_STATES)-1:0] count,
    output logic [$clog2(NUM_STATES)-1:0] count_next
);

    localparam int PW = $clog2(NUM_STATES);
    localparam logic [PW-1:0] LAST_PHASE  = PW'(NUM_STATES - 1);
    localparam logic [PW-1:0] START_PHASE = PW'(INIT_PHASE);

    logic [PW-1:0] count_reg;

    // Next phase: clear beats load beats advance; advance wraps at the last phase.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next = START_PHASE;
        end else if (enable) begin
            count_next = (count_reg == LAST_PHASE) ? '0 : count_reg + 1'b1;
        end
    end

    // Phase register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/cute_lock_key_sequencer.sv
// Trusted-side key sequencer for a counter-based time-varying-key locked core.
// A schedule of NUM_STATES key words is streamed in once, then replayed one
// word per cycle in lock-step with the core's mod-N phase counter. keyinput
// is always a registered table read, never a path from key_data.
module cute_lock_key_sequencer
    import cute_lock_pkg::*;
#(
    parameter int KEY_W      = DEFAULT_KEY_W,
    parameter int NUM_STATES = DEFAULT_NUM_STATES,
    parameter int INIT_PHASE = DEFAULT_INIT_PHASE
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          key_valid,
    output logic                          key_ready,
    input  logic [KEY_W-1:0]              key_data,
    input  logic                          run_start,
    input  logic                          run_stop,
    input  logic                          zeroize,
    output logic [KEY_W-1:0]              keyinput,
    output logic [$clog2(NUM_STATES)-1:0] phase,
    output logic                          loaded,
    output logic                          running
);

    localparam int PW = $clog2(NUM_STATES);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_STATES - 1);

    seq_state_t    state_reg;
    seq_state_t    state_next;

    logic [KEY_W-1:0] table_reg [NUM_STATES];
    logic [PW-1:0]    wr_idx_reg;
    logic [KEY_W-1:0] keyinput_reg;
    logic             loaded_reg;
    logic             running_reg;

    logic             zero_go;
    logic             stop_go;
    logic             start_go;
    logic             beat_go;
    logic             last_beat;
    logic [PW-1:0]    phase_next;

    assign key_ready = (state_reg == IDLE) || (state_reg == LOAD);
    assign last_beat = (wr_idx_reg == LAST_IDX);

    // Next-state and action decode; zeroize outranks stop, stop outranks start.
    always_comb begin
        state_next = state_reg;
        zero_go    = 1'b0;
        stop_go    = 1'b0;
        start_go   = 1'b0;
        beat_go    = 1'b0;
        if (zeroize) begin
            zero_go    = 1'b1;
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, LOAD: begin
                    if (key_valid) begin
                        beat_go    = 1'b1;
                        state_next = last_beat ? ARMED : LOAD;
                    end
                end
                ARMED: begin
                    if (run_stop) begin
                        stop_go = 1'b1;
                    end else if (run_start) begin
                        start_go   = 1'b1;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (run_stop) begin
                        stop_go    = 1'b1;
                        state_next = ARMED;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Schedule entries: each slot captures the beat addressed to it, erased on zeroize.
    generate
        for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_table
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    table_reg[gi] <= '0;
                end else if (zero_go) begin
                    table_reg[gi] <= '0;
                end else if (beat_go && (wr_idx_reg == PW'(gi))) begin
                    table_reg[gi] <= key_data;
                end
            end
        end
    endgenerate

    // Write index and loaded flag track load progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_idx_reg <= '0;
            loaded_reg <= 1'b0;
        end else if (zero_go) begin
            wr_idx_reg <= '0;
            loaded_reg <= 1'b0;
        end else if (beat_go) begin
            wr_idx_reg <= last_beat ? '0 : wr_idx_reg + 1'b1;
            if (last_beat) begin
                loaded_reg <= 1'b1;
            end
        end
    end

    // Phase counter: restarts at INIT_PHASE on start or stop, advances while replaying.
    cute_lock_phase_counter #(
        .NUM_STATES (NUM_STATES),
        .INIT_PHASE (INIT_PHASE)
    ) u_phase_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (zero_go),
        .load       (stop_go || start_go),
        .enable     (state_reg == RUN),
        .count      (phase),
        .count_next (phase_next)
    );

    // Key output and running flag: the table word for the phase of the next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            keyinput_reg <= '0;
            running_reg  <= 1'b0;
        end else if (zero_go || stop_go) begin
            keyinput_reg <= '0;
            running_reg  <= 1'b0;
        end else if (start_go || (state_reg == RUN)) begin
            keyinput_reg <= table_reg[phase_next];
            running_reg  <= 1'b1;
        end
    end

    assign keyinput = keyinput_reg;
    assign loaded   = loaded_reg;
    assign running  = running_reg;

endmodule
